// File: rtl/pio_out_pkg.sv
// Shared constants for the multi-channel output PIO: register offsets,
// overrun counter width and STATUS bit positions.
package pio_out_pkg;

    typedef enum logic [1:0] {
        OFF_DATA   = 2'd0,
        OFF_SET    = 2'd1,
        OFF_CLR    = 2'd2,
        OFF_STATUS = 2'd3
    } reg_off_e;

    localparam int OVR_W = 8;
    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_OVR_LSB = 8;
    localparam logic [OVR_W-1:0] OVR_MAX = '1;

endpackage

// File: rtl/pio_out_bank_if.sv
// Avalon-MM slave bus bundle for pio_out_bank; AW must equal $clog2(CHANNELS)+2.
interface pio_out_bank_if #(
    parameter int AW = 3
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_out_channel.sv
// One output channel: data register, valid flag, and (with PIO_OUT_OVERRUN_CNT_EN)
// an 8-bit saturating overrun counter.
module pio_out_channel
    import pio_out_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  reg_off_e         offset,
    input  logic [31:0]      wdata,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [OVR_W-1:0] ovr_cnt
);

    logic [WIDTH-1:0] data_q, data_d, wd;
    logic             valid_q, valid_d;
    logic             upd, xfer;

    assign wd = wdata[WIDTH-1:0];

    always_comb begin
        upd     = wr_en && (offset != OFF_STATUS);
        xfer    = valid_q && ready;
        data_d  = data_q;
        valid_d = valid_q;
        if (upd) begin
            case (offset)
                OFF_DATA: data_d = wd;
                OFF_SET:  data_d = data_q | wd;
                OFF_CLR:  data_d = data_q & ~wd;
                default:  data_d = data_q;
            endcase
        end
        // An update in the transfer cycle re-arms valid for the new value.
        if (xfer) valid_d = 1'b0;
        if (upd)  valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

`ifdef PIO_OUT_OVERRUN_CNT_EN
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             overrun;

    always_comb begin
        overrun = upd && valid_q && !ready;
        ovr_d   = ovr_q;
        if (overrun && (ovr_q != OVR_MAX)) ovr_d = ovr_q + 1'b1;
        if (wr_en && (offset == OFF_STATUS) && wdata[0]) ovr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) ovr_q <= '0;
        else       ovr_q <= ovr_d;
    end

    assign ovr_cnt = ovr_q;
`else
    logic unused_wdata;
    assign unused_wdata = ^wdata;
    assign ovr_cnt = '0;
`endif

endmodule

// File: rtl/pio_out_bank.sv
// Multi-channel Avalon-MM output PIO with DATA/SET/CLEAR/STATUS per channel.
// Optional overrun counters are enabled by defining PIO_OUT_OVERRUN_CNT_EN.
module pio_out_bank
    import pio_out_pkg::*;
#(
    parameter  int WIDTH    = 15,
    parameter  int CHANNELS = 2,
    localparam int AW       = $clog2(CHANNELS) + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    pio_out_bank_if.slave             bus,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready
);

    logic [AW-1:0]    addr;
    logic [31:0]      ch_sel;
    reg_off_e         offset;
    logic             wr;
    logic [WIDTH-1:0] data_arr [CHANNELS];
    logic [OVR_W-1:0] ovr_arr  [CHANNELS];

    assign addr   = bus.address;
    assign ch_sel = 32'(addr >> 2);
    assign offset = reg_off_e'(addr[1:0]);
    assign wr     = bus.chipselect && !bus.write_n;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pio_out_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr && (ch_sel == 32'(c))),
            .offset  (offset),
            .wdata   (bus.writedata),
            .ready   (out_ready[c]),
            .data    (data_arr[c]),
            .valid   (out_valid[c]),
            .ovr_cnt (ovr_arr[c])
        );
        assign out_port[c*WIDTH +: WIDTH] = data_arr[c];
    end

    // Out-of-range channel indices fall through to zero.
    always_comb begin
        bus.readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == 32'(c)) begin
                if (offset == OFF_STATUS) begin
                    bus.readdata[STAT_VALID_BIT]          = out_valid[c];
                    bus.readdata[STAT_OVR_LSB +: OVR_W]   = ovr_arr[c];
                end else begin
                    bus.readdata[WIDTH-1:0] = data_arr[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_out_bank.sv
// Directed self-checking bench for pio_out_bank (WIDTH=15, CHANNELS=2).
module tb_pio_out_bank;

    localparam int WIDTH = 15;
    localparam int CH    = 2;
    localparam int AW    = 3;

    logic              clk;
    logic              reset;
    logic [CH*WIDTH-1:0] out_port;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;

    int n_cmp = 0;
    int n_err = 0;

    pio_out_bank_if #(.AW(AW)) bus ();

    pio_out_bank #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.address    = '0;
        bus.writedata  = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        out_ready      = '0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        rd_check("rst_ch0_data", 3'd0, 32'h0);
        rd_check("rst_ch1_data", 3'd4, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_port", 32'(out_port), 32'h0);

        // Upper bits of writedata are dropped.
        wr(3'd4, 32'hFFFF_7ABC);
        check("ch1_port", 32'(out_port[WIDTH +: WIDTH]), 32'h7ABC);
        rd_check("ch1_read", 3'd4, 32'h0000_7ABC);
        check("ch1_valid", 32'(out_valid), 32'h2);

        out_ready = 2'b10;
        tick();
        out_ready = 2'b00;
        check("ch1_xfer", 32'(out_valid), 32'h0);

        wr(3'd0, 32'h0000_00F0);
        wr(3'd1, 32'h0000_000F);
        check("ch0_set", 32'(out_port[0 +: WIDTH]), 32'h00FF);

        // Transfer of 0x00FF coincides with the CLEAR update.
        out_ready = 2'b01;
        #1;
        check("ch0_pre_xfer_port", 32'(out_port[0 +: WIDTH]), 32'h00FF);
        wr(3'd2, 32'h0000_0030);
        check("ch0_clr", 32'(out_port[0 +: WIDTH]), 32'h00CF);
        check("ch0_valid_kept", 32'(out_valid), 32'h1);
        rd_check("ch0_read", 3'd0, 32'h0000_00CF);
        tick();
        out_ready = 2'b00;
        check("ch0_xfer", 32'(out_valid), 32'h0);

        wr(3'd0, 32'h1);
        wr(3'd1, 32'h2);
        wr(3'd2, 32'h1);
        check("ch0_after3", 32'(out_port[0 +: WIDTH]), 32'h2);
`ifdef PIO_OUT_OVERRUN_CNT_EN
        rd_check("status_2ovr", 3'd3, 32'h0000_0201);
`else
        rd_check("status_2ovr", 3'd3, 32'h0000_0001);
`endif
        out_ready = 2'b01;
        tick();
        out_ready = 2'b00;
`ifdef PIO_OUT_OVERRUN_CNT_EN
        rd_check("status_after_xfer", 3'd3, 32'h0000_0200);
`else
        rd_check("status_after_xfer", 3'd3, 32'h0000_0000);
`endif
        wr(3'd3, 32'h1);
        rd_check("status_cleared", 3'd3, 32'h0);

        wr(3'd0, 32'h5);
        for (int i = 0; i < 300; i++) wr(3'd1, 32'h0);
`ifdef PIO_OUT_OVERRUN_CNT_EN
        rd_check("status_sat", 3'd3, 32'h0000_FF01);
`else
        rd_check("status_sat", 3'd3, 32'h0000_0001);
`endif
        wr(3'd3, 32'h1);
        rd_check("status_sat_clr", 3'd3, 32'h0000_0001);
        check("data_after_status_wr", 32'(out_port[0 +: WIDTH]), 32'h5);
        rd_check("ch1_status", 3'd7, 32'h0);

        // Reset wins over a simultaneous write while ch0 has valid pending.
        bus.address    = 3'd4;
        bus.writedata  = 32'h1234;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        reset          = 1'b1;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b0;
        check("rst_wr_port", 32'(out_port), 32'h0);
        check("rst_wr_valid", 32'(out_valid), 32'h0);
        rd_check("rst_wr_ch1", 3'd4, 32'h0);
        rd_check("rst_wr_status", 3'd3, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
